// File: rtl/mux_scan_capture.sv
// mux_scan_capture
//   Sweeps the select lines of an external mux tree from 0 to N-1, holds each
//   select value for SETTLE+1 cycles, samples the single-bit mux output on the
//   last of those cycles, and presents the assembled N-bit word with a
//   valid/ready handshake.
//
// Ports
//   clk         system clock, all state on rising edge
//   rst_n       asynchronous active-low reset
//   start       one-cycle scan request, honoured only in IDLE or DONE
//   sel         registered select driven to the mux under scan
//   mux_out     mux output bit, combinational function of sel
//   data        captured word, bit i = mux_out sampled while sel == i
//   data_valid  data holds a complete, not yet accepted scan result
//   data_ready  consumer accepts data when data_valid && data_ready
//   busy        high while a scan is in progress
//
// States
//   IDLE | no scan running, sel parked at 0
//   SCAN | sweeping sel, sampling mux_out into the shadow register
//   DONE | result held in data until the consumer accepts it

module mux_scan_capture #(
  parameter int SEL_W  = 5,
  parameter int SETTLE = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic [SEL_W-1:0]        sel,
  input  logic                    mux_out,
  output logic [(2**SEL_W)-1:0]   data,
  output logic                    data_valid,
  input  logic                    data_ready,
  output logic                    busy
);

  localparam int N = 2**SEL_W;
  localparam logic [3:0]       SETTLE_C = 4'(SETTLE);
  localparam logic [SEL_W-1:0] SEL_LAST = {SEL_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nx;
  logic [SEL_W-1:0] sel_nx;
  logic [3:0]       wait_cnt, wait_nx;
  logic [N-1:0]     shadow, shadow_nx;
  logic [N-1:0]     data_nx;
  logic             valid_nx;
  logic             busy_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      wait_cnt   <= '0;
      shadow     <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      sel        <= sel_nx;
      wait_cnt   <= wait_nx;
      shadow     <= shadow_nx;
      data       <= data_nx;
      data_valid <= valid_nx;
      busy       <= busy_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    sel_nx    = sel;
    wait_nx   = wait_cnt;
    shadow_nx = shadow;
    data_nx   = data;
    valid_nx  = data_valid;
    busy_nx   = busy;

    case (state)
      IDLE: begin
        sel_nx = '0;
        if (start) begin
          state_nx  = SCAN;
          wait_nx   = '0;
          shadow_nx = '0;
          busy_nx   = 1'b1;
        end
      end

      SCAN: begin
        if (wait_cnt != SETTLE_C) begin
          wait_nx = wait_cnt + 4'd1;
        end else begin
          shadow_nx[sel] = mux_out;
          wait_nx        = '0;
          if (sel == SEL_LAST) begin
            // The final bit goes straight into data; shadow only lands a cycle later.
            data_nx        = shadow;
            data_nx[N-1]   = mux_out;
            valid_nx       = 1'b1;
            busy_nx        = 1'b0;
            sel_nx         = '0;
            state_nx       = DONE;
          end else begin
            sel_nx = sel + {{(SEL_W-1){1'b0}}, 1'b1};
          end
        end
      end

      DONE: begin
        // start alone is ignored here so an unaccepted result is never lost.
        if (data_valid && data_ready) begin
          valid_nx = 1'b0;
          if (start) begin
            state_nx  = SCAN;
            sel_nx    = '0;
            wait_nx   = '0;
            shadow_nx = '0;
            busy_nx   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        sel_nx   = '0;
        wait_nx  = '0;
        valid_nx = 1'b0;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mux_scan_capture.sv
module tb_mux_scan_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, data_ready, mux_out, data_valid, busy;
  logic [4:0]  sel;
  logic [31:0] data;
  logic        start0, data_ready0, mux_out0, data_valid0, busy0;
  logic [4:0]  sel0;
  logic [31:0] data0;
  logic [31:0] bank, bank0;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Behavioural stand-in for the mux tree under scan
  assign mux_out  = bank[sel];
  assign mux_out0 = bank0[sel0];

  mux_scan_capture #(.SEL_W(5), .SETTLE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .mux_out(mux_out),
    .data(data), .data_valid(data_valid), .data_ready(data_ready), .busy(busy)
  );

  mux_scan_capture #(.SEL_W(5), .SETTLE(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .sel(sel0), .mux_out(mux_out0),
    .data(data0), .data_valid(data_valid0), .data_ready(data_ready0), .busy(busy0)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Counts edges until data_valid rises, giving up after budget edges.
  task automatic wait_valid(input bit which, input int budget, output int n);
    n = 0;
    while (((which == 1'b0) ? data_valid : data_valid0) !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({sel, data, data_valid, busy} !== 39'd0) begin
      failures++;
      $display("FAIL reset_state: got %h required 0", {sel, data, data_valid, busy});
    end
    checks++;
    if ({sel0, data0, data_valid0, busy0} !== 39'd0) begin
      failures++;
      $display("FAIL reset_state0: got %h required 0", {sel0, data0, data_valid0, busy0});
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      checks++;
      if ({sel, data, data_valid, busy, sel0, data0, data_valid0, busy0} !== 78'd0) begin
        failures++;
        $display("FAIL idle_hold cycle %0d: got %h/%h required 0", c,
                 {sel, data, data_valid, busy}, {sel0, data0, data_valid0, busy0});
      end
    end
  endtask

  task automatic test_alternating;
    logic [31:0] want;
    bank = 32'h5555_5555;
    data_ready = 1'b1;
    exp_q.push_back(bank);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || sel !== 5'd0) begin
      failures++;
      $display("FAIL alt_accept: busy=%b sel=%0d required busy=1 sel=0", busy, sel);
    end
    for (int e = 1; e <= 65; e++) begin
      @(posedge clk); #1;
      checks++;
      if (e < 64) begin
        if (busy !== 1'b1 || data_valid !== 1'b0 || sel !== 5'(e / 2)) begin
          failures++;
          $display("FAIL alt_progress edge %0d: sel=%0d busy=%b dv=%b required sel=%0d busy=1 dv=0",
                   e, sel, busy, data_valid, e / 2);
        end
      end else if (e == 64) begin
        if (data_valid !== 1'b1 || busy !== 1'b0 || sel !== 5'd0) begin
          failures++;
          $display("FAIL alt_complete: dv=%b busy=%b sel=%0d required dv=1 busy=0 sel=0",
                   data_valid, busy, sel);
        end
        want = exp_q.pop_front();
        checks++;
        if (data !== want) begin
          failures++;
          $display("FAIL alt_data: got %h required %h", data, want);
        end
      end else begin
        if (data_valid !== 1'b0 || data !== 32'h5555_5555 || busy !== 1'b0) begin
          failures++;
          $display("FAIL alt_handshake: dv=%b data=%h busy=%b required dv=0 data=55555555 busy=0",
                   data_valid, data, busy);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] want;
    int n;
    bank = 32'hDEAD_BEEF;
    data_ready = 1'b0;
    exp_q.push_back(bank);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(1'b0, 200, n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL bp_latency: got %0d edges required 64", n);
    end
    want = exp_q.pop_front();
    checks++;
    if (data !== want) begin
      failures++;
      $display("FAIL bp_data: got %h required %h", data, want);
    end
    bank = 32'h0000_0000;
    for (int c = 0; c < 10; c++) begin
      start = (c == 2 || c == 6);
      @(posedge clk); #1;
      checks++;
      if (data_valid !== 1'b1 || data !== 32'hDEAD_BEEF || busy !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold cycle %0d: dv=%b data=%h busy=%b required dv=1 data=deadbeef busy=0",
                 c, data_valid, data, busy);
      end
    end
    start = 1'b0;
    bank = 32'h1234_5678;
    exp_q.push_back(bank);
    data_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++;
    if (data_valid !== 1'b0 || busy !== 1'b1 || sel !== 5'd0 || data !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL b2b_restart: dv=%b busy=%b sel=%0d data=%h required dv=0 busy=1 sel=0 data=deadbeef",
               data_valid, busy, sel, data);
    end
    wait_valid(1'b0, 200, n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL b2b_latency: got %0d edges required 64", n);
    end
    want = exp_q.pop_front();
    checks++;
    if (data !== want) begin
      failures++;
      $display("FAIL b2b_data: got %h required %h", data, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_settle0;
    logic [31:0] want;
    bank0 = 32'h8000_0001;
    data_ready0 = 1'b1;
    exp_q.push_back(bank0);
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    for (int e = 1; e <= 32; e++) begin
      @(posedge clk); #1;
      checks++;
      if (e < 32) begin
        if (sel0 !== 5'(e) || data_valid0 !== 1'b0 || busy0 !== 1'b1) begin
          failures++;
          $display("FAIL s0_progress edge %0d: sel=%0d dv=%b busy=%b required sel=%0d dv=0 busy=1",
                   e, sel0, data_valid0, busy0, e);
        end
      end else begin
        if (data_valid0 !== 1'b1 || sel0 !== 5'd0 || busy0 !== 1'b0) begin
          failures++;
          $display("FAIL s0_complete: dv=%b sel=%0d busy=%b required dv=1 sel=0 busy=0",
                   data_valid0, sel0, busy0);
        end
        want = exp_q.pop_front();
        checks++;
        if (data0 !== want) begin
          failures++;
          $display("FAIL s0_data: got %h required %h", data0, want);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_scan;
    logic [31:0] want;
    int e;
    int n;
    bank = 32'hA5C3_0F96;
    data_ready = 1'b1;
    exp_q.push_back(bank);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    while (sel !== 5'd17 && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    checks++;
    if (sel !== 5'd17) begin
      failures++;
      $display("FAIL mid_reach17: got sel=%0d required 17", sel);
    end
    rst_n = 1'b0;
    void'(exp_q.pop_back());
    #1;
    checks++;
    if (sel !== 5'd0 || busy !== 1'b0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: sel=%0d busy=%b dv=%b required 0/0/0", sel, busy, data_valid);
    end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (data !== 32'd0 || data_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset_data: data=%h dv=%b required 0/0", data, data_valid);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    bank = 32'h3C96_E1F0;
    exp_q.push_back(bank);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(1'b0, 200, n);
    checks++;
    if (n !== 64) begin
      failures++;
      $display("FAIL mid_fresh_latency: got %0d edges required 64", n);
    end
    want = exp_q.pop_front();
    checks++;
    if (data !== want) begin
      failures++;
      $display("FAIL mid_fresh_data: got %h required %h", data, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_during_scan;
    logic [31:0] want;
    int e;
    int n;
    bank = 32'h0F0F_1234;
    data_ready = 1'b1;
    exp_q.push_back(bank);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = 0;
    while (sel !== 5'd5 && e < 200) begin
      @(posedge clk); #1;
      e++;
    end
    start = 1'b1;
    @(posedge clk); #1;
    e++;
    start = 1'b0;
    checks++;
    if (sel !== 5'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL sds_no_restart: sel=%0d busy=%b required sel=5 busy=1", sel, busy);
    end
    wait_valid(1'b0, 200, n);
    checks++;
    if (e + n !== 64) begin
      failures++;
      $display("FAIL sds_latency: got %0d edges required 64", e + n);
    end
    want = exp_q.pop_front();
    checks++;
    if (data !== want) begin
      failures++;
      $display("FAIL sds_data: got %h required %h", data, want);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    data_ready  = 1'b0;
    start0      = 1'b0;
    data_ready0 = 1'b0;
    bank        = 32'd0;
    bank0       = 32'd0;
    test_reset();
    test_alternating();
    test_back_to_back();
    test_settle0();
    test_reset_mid_scan();
    test_start_during_scan();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
